// File: rtl/instr_collector_if.sv
// Handshake bundle between fetch, the instruction collector and the decode stage.
// "master" is the environment side and "slave" is the collector side.
interface instr_collector_if #(
   parameter int WFID_W = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [WFID_W-1:0] in_wfid;
   logic [31:0]       in_pc;
   logic [31:0]       in_instr;
   logic              flush_valid;
   logic [WFID_W-1:0] flush_wfid;
   logic              half_rqd;
   logic [WFID_W-1:0] half_wfid;
   logic              out_valid;
   logic              out_ready;
   logic [WFID_W-1:0] out_wfid;
   logic [31:0]       out_pc;
   logic [63:0]       out_instr;
   logic              out_is64;
   logic              out_literal;

   modport master (
      output in_valid, in_wfid, in_pc, in_instr, flush_valid, flush_wfid, out_ready,
      input  in_ready, half_rqd, half_wfid, out_valid, out_wfid, out_pc, out_instr,
             out_is64, out_literal
   );

   modport slave (
      input  in_valid, in_wfid, in_pc, in_instr, flush_valid, flush_wfid, out_ready,
      output in_ready, half_rqd, half_wfid, out_valid, out_wfid, out_pc, out_instr,
             out_is64, out_literal
   );
endinterface

// File: rtl/instr_collector.sv
// Joins 32-bit fetch words into 32- or 64-bit instructions, one pending first half per wavefront,
// and presents them through a single registered output stage.
module instr_collector #(
   parameter int NUM_WF = 40,
   parameter int WFID_W = 6
) (
   input logic              clk,
   input logic              rst,
   instr_collector_if.slave bus
);
   localparam logic [WFID_W:0] NUM_WF_L = (WFID_W+1)'(NUM_WF);

   logic [NUM_WF-1:0] pending_reg;
   logic [NUM_WF-1:0] pending_next;
   logic [31:0]       first_word_mem [NUM_WF];
   logic [31:0]       first_pc_mem   [NUM_WF];
   logic              first_lit_mem  [NUM_WF];

   logic              out_valid_reg;
   logic [WFID_W-1:0] out_wfid_reg;
   logic [31:0]       out_pc_reg;
   logic [63:0]       out_instr_reg;
   logic              out_is64_reg;
   logic              out_literal_reg;
   logic              half_rqd_reg;
   logic [WFID_W-1:0] half_wfid_reg;

   logic       in_ready;
   logic       in_hit;
   logic       flush_hit;
   logic       flush_same;
   logic       cur_pending;
   logic [5:0] op6;
   logic       is_two;
   logic       is_lit;
   logic       start_pair;
   logic       emit_single;
   logic       emit_pair;

   assign in_ready   = !out_valid_reg | bus.out_ready;
   assign in_hit     = bus.in_valid & in_ready & ({1'b0, bus.in_wfid} < NUM_WF_L);
   assign flush_hit  = bus.flush_valid & ({1'b0, bus.flush_wfid} < NUM_WF_L);
   assign flush_same = flush_hit & (bus.flush_wfid == bus.in_wfid);
   // A flush in the same cycle wins, so the incoming word is then a fresh first word.
   assign cur_pending = in_hit & pending_reg[bus.in_wfid] & !flush_same;

   assign op6    = bus.in_instr[31:26];
   assign is_two = (op6 == 6'b111000) | (op6 == 6'b111010) | (op6 == 6'b111100) |
                   (op6 == 6'b111110) | (op6 == 6'b110110) | (op6 == 6'b110100);
   assign is_lit = ((bus.in_instr[31:23] == 9'b101111101) & (bus.in_instr[7:0] == 8'hFF)) |
                   ((bus.in_instr[31:23] == 9'b101111110) &
                    ((bus.in_instr[7:0] == 8'hFF) | (bus.in_instr[15:8] == 8'hFF))) |
                   ((bus.in_instr[31:25] == 7'b0111111) & (bus.in_instr[8:0] == 9'h1FF));

   assign start_pair  = in_hit & !cur_pending & (is_two | is_lit);
   assign emit_single = in_hit & !cur_pending & !(is_two | is_lit);
   assign emit_pair   = cur_pending;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WF; gi++) begin : g_slot
         assign pending_next[gi] =
            (in_hit && bus.in_wfid == WFID_W'(gi)) ? start_pair :
            (pending_reg[gi] & !(flush_hit && bus.flush_wfid == WFID_W'(gi)));
      end
   endgenerate

   // First-half storage is only meaningful while the pending bit is set, so it needs no reset.
   always_ff @(posedge clk) begin
      if (start_pair) begin
         first_word_mem[bus.in_wfid] <= bus.in_instr;
         first_pc_mem[bus.in_wfid]   <= bus.in_pc;
         first_lit_mem[bus.in_wfid]  <= is_lit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_reg     <= '0;
         out_valid_reg   <= 1'b0;
         out_wfid_reg    <= '0;
         out_pc_reg      <= '0;
         out_instr_reg   <= '0;
         out_is64_reg    <= 1'b0;
         out_literal_reg <= 1'b0;
         half_rqd_reg    <= 1'b0;
         half_wfid_reg   <= '0;
      end else begin
         pending_reg  <= pending_next;
         half_rqd_reg <= start_pair;
         if (start_pair)
            half_wfid_reg <= bus.in_wfid;
         if (emit_single | emit_pair) begin
            out_valid_reg <= 1'b1;
            out_wfid_reg  <= bus.in_wfid;
            if (emit_pair) begin
               out_pc_reg      <= first_pc_mem[bus.in_wfid];
               out_instr_reg   <= {bus.in_instr, first_word_mem[bus.in_wfid]};
               out_is64_reg    <= 1'b1;
               out_literal_reg <= first_lit_mem[bus.in_wfid];
            end else begin
               out_pc_reg      <= bus.in_pc;
               out_instr_reg   <= {32'h0, bus.in_instr};
               out_is64_reg    <= 1'b0;
               out_literal_reg <= 1'b0;
            end
         end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.half_rqd    = half_rqd_reg;
   assign bus.half_wfid   = half_wfid_reg;
   assign bus.out_valid   = out_valid_reg;
   assign bus.out_wfid    = out_wfid_reg;
   assign bus.out_pc      = out_pc_reg;
   assign bus.out_instr   = out_instr_reg;
   assign bus.out_is64    = out_is64_reg;
   assign bus.out_literal = out_literal_reg;
endmodule
